// File: rtl/alarm_sequencer_pkg.sv
// Shared definitions for the alarm sequencer: state encodings and counter sizing.
// State encoding doubles as the LED pattern: state[0] drives LED0, state[1] drives LED1,
// so IDLE=off/off, ARMED=LED0, RINGING=LED1, SNOOZE=both.
package alarm_sequencer_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_RINGING = 2'd2;
  localparam logic [1:0] ST_SNOOZE  = 2'd3;

  // Width of the shared seconds counter; it only ever holds max-1, never less than 1 bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/alarm_sequencer_sec_countdown.sv
// Loadable seconds down-counter with tick enable and zero flag.
// Latency: load/decrement visible one cycle after the enabling edge; zero is decoded from the register.
// Backpressure: none; load has priority over tick, and the count holds at zero.
module sec_countdown #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  // Load wins over a decrement; saturate at zero so a stray tick never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm-state controller: edge-triggered HH:MM match, arm/ring/snooze/stop sequencing, buzzer gating.
// Latency: one cycle from trig/button/tick sample to registered state and outputs.
// Backpressure: none; inputs are single-cycle pulses, button beats tick. Snooze built only with ALARM_SNOOZE_EN.
module alarm_sequencer
  import alarm_sequencer_pkg::*;
#(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 540,
  parameter int SNOOZE_MAX     = 3
) (
  input  logic       MCLK,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  input  logic [7:0] alm_hh,
  input  logic [7:0] alm_mm,
  input  logic       alarm_en,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       ringing,
  output logic       buzz,
  output logic       snoozing,
  output logic [3:0] snooze_left,
  output logic [1:0] state
);

  localparam int CW = cnt_width(RING_TIMEOUT_S, SNOOZE_S);
  localparam logic [CW-1:0] RING_LD = CW'(RING_TIMEOUT_S - 1);

  logic          match, match_q, trig;
  logic [1:0]    state_nxt;
  logic          phase, phase_nxt;
  logic          cnt_ld, cnt_dec, cnt_zero;
  logic [CW-1:0] cnt_ld_val, cnt_val;

  assign match = ({cur_hh, cur_mm} == {alm_hh, alm_mm});
  assign trig  = match & ~match_q;

`ifdef ALARM_SNOOZE_EN
  localparam logic [CW-1:0] SNZ_LD = CW'(SNOOZE_S - 1);
  logic [3:0] left_q, left_nxt;
`else
  // Snooze configuration is accepted but has no hardware in this build.
  logic [4:0] unused_snooze;
  assign unused_snooze = {snooze_btn, 4'(SNOOZE_MAX)};
`endif

  // Next-state decode; priority: disable, stop, snooze, tick, trig.
  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    cnt_ld     = 1'b0;
    cnt_ld_val = RING_LD;
    cnt_dec    = 1'b0;
`ifdef ALARM_SNOOZE_EN
    left_nxt   = left_q;
`endif
    if (!alarm_en) begin
      state_nxt = ST_IDLE;
      phase_nxt = 1'b0;
`ifdef ALARM_SNOOZE_EN
      left_nxt  = 4'd0;
`endif
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_ARMED;
        ST_ARMED: begin
          if (trig) begin
            state_nxt = ST_RINGING;
            cnt_ld    = 1'b1;
            phase_nxt = 1'b1;
`ifdef ALARM_SNOOZE_EN
            left_nxt  = 4'(SNOOZE_MAX);
`endif
          end
        end
        ST_RINGING: begin
          if (stop_btn) begin
            state_nxt = ST_ARMED;
            phase_nxt = 1'b0;
`ifdef ALARM_SNOOZE_EN
            left_nxt  = 4'd0;
          end else if (snooze_btn && (left_q != 4'd0)) begin
            state_nxt  = ST_SNOOZE;
            cnt_ld     = 1'b1;
            cnt_ld_val = SNZ_LD;
            left_nxt   = left_q - 4'd1;
`endif
          end else if (tick_1hz) begin
            if (cnt_zero) begin
              state_nxt = ST_ARMED;
              phase_nxt = 1'b0;
`ifdef ALARM_SNOOZE_EN
              left_nxt  = 4'd0;
`endif
            end else begin
              cnt_dec   = 1'b1;
              phase_nxt = ~phase;
            end
          end
        end
        default: begin
`ifdef ALARM_SNOOZE_EN
          // SNOOZE: a repeated snooze press is a no-op, so the tick still counts.
          if (stop_btn) begin
            state_nxt = ST_ARMED;
            phase_nxt = 1'b0;
            left_nxt  = 4'd0;
          end else if (tick_1hz) begin
            if (cnt_zero) begin
              state_nxt = ST_RINGING;
              cnt_ld    = 1'b1;
              phase_nxt = 1'b1;
            end else begin
              cnt_dec = 1'b1;
            end
          end
`else
          state_nxt = ST_ARMED;
          phase_nxt = 1'b0;
`endif
        end
      endcase
    end
  end

  // State, buzzer phase and match history registers.
  always_ff @(posedge MCLK or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      phase   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      match_q <= match;
    end
  end

`ifdef ALARM_SNOOZE_EN
  // Remaining snoozes for the current alarm event.
  always_ff @(posedge MCLK or negedge rst_n) begin
    if (!rst_n) begin
      left_q <= 4'd0;
    end else begin
      left_q <= left_nxt;
    end
  end

  assign snoozing    = (state == ST_SNOOZE);
  assign snooze_left = left_q;
`else
  assign snoozing    = 1'b0;
  assign snooze_left = 4'd0;
`endif

  sec_countdown #(.WIDTH(CW)) u_cnt (
    .clk      (MCLK),
    .rst_n    (rst_n),
    .load     (cnt_ld),
    .load_val (cnt_ld_val),
    .tick     (cnt_dec),
    .count    (cnt_val),
    .zero     (cnt_zero)
  );

  assign ringing = (state == ST_RINGING);
  assign buzz    = ringing & phase;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with RING_TIMEOUT_S=5, SNOOZE_S=3, SNOOZE_MAX=2, alarm 07:30.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
module tb_alarm_sequencer;

  logic       MCLK = 1'b0;
  logic       rst_n;
  logic       tick_1hz, alarm_en, snooze_btn, stop_btn;
  logic [7:0] cur_hh, cur_mm, alm_hh, alm_mm;
  logic       ringing, buzz, snoozing;
  logic [3:0] snooze_left;
  logic [1:0] state;

  int n_chk = 0;
  int n_bad = 0;

`ifdef ALARM_SNOOZE_EN
  localparam logic [3:0] LEFT_ON_RING = 4'd2;
`else
  localparam logic [3:0] LEFT_ON_RING = 4'd0;
`endif

  always #5 MCLK = ~MCLK;

  alarm_sequencer #(.RING_TIMEOUT_S(5), .SNOOZE_S(3), .SNOOZE_MAX(2)) dut (
    .MCLK        (MCLK),
    .rst_n       (rst_n),
    .tick_1hz    (tick_1hz),
    .cur_hh      (cur_hh),
    .cur_mm      (cur_mm),
    .alm_hh      (alm_hh),
    .alm_mm      (alm_mm),
    .alarm_en    (alarm_en),
    .snooze_btn  (snooze_btn),
    .stop_btn    (stop_btn),
    .ringing     (ringing),
    .buzz        (buzz),
    .snoozing    (snoozing),
    .snooze_left (snooze_left),
    .state       (state)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge MCLK);
    #1;
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
  endtask

  task automatic press(input logic snz, input logic stp, input logic tk);
    snooze_btn = snz;
    stop_btn   = stp;
    tick_1hz   = tk;
    cyc();
    snooze_btn = 1'b0;
    stop_btn   = 1'b0;
    tick_1hz   = 1'b0;
  endtask

  // From ARMED: leave the matching minute and come back to produce a fresh edge.
  task automatic retrigger();
    cur_mm = 8'h31;
    cyc();
    cur_mm = 8'h30;
    cyc();
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] st, input logic r, input logic b,
                          input logic s, input logic [3:0] sl);
    chk({tag, ".state"}, 16'(state), 16'(st));
    chk({tag, ".ringing"}, 16'(ringing), 16'(r));
    chk({tag, ".buzz"}, 16'(buzz), 16'(b));
    chk({tag, ".snoozing"}, 16'(snoozing), 16'(s));
    chk({tag, ".snooze_left"}, 16'(snooze_left), 16'(sl));
  endtask

  initial begin
    rst_n = 1'b0; tick_1hz = 1'b0; alarm_en = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
    cur_hh = 8'h07; cur_mm = 8'h29; alm_hh = 8'h07; alm_mm = 8'h30;
    #12;
    chk_outs("reset", 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("idle_hold", 16'(state), 16'd0);

    // 1: arm, then 07:29 -> 07:30 rings the next cycle with buzz 1,0,1,0,1 per tick.
    alarm_en = 1'b1;
    cyc();
    chk("armed", 16'(state), 16'd1);
    cur_mm = 8'h30;
    cyc();
    chk_outs("ring_start", 2'd2, 1'b1, 1'b1, 1'b0, LEFT_ON_RING);
    cyc();
    chk("ring_no_tick_hold", 16'(buzz), 16'd1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("buzz_t%0d", i), 16'(buzz), 16'(((i % 2) == 0) ? 1 : 0));
      chk($sformatf("ringing_t%0d", i), 16'(ringing), 16'd1);
      tick();
    end
    chk_outs("timeout", 2'd1, 1'b0, 1'b0, 1'b0, 4'd0);
    repeat (3) cyc();
    chk("no_retrig_same_minute", 16'(state), 16'd1);

    // 2: enabling during the matching minute must not ring; a fresh edge does.
    alarm_en = 1'b0;
    cyc();
    chk("disable_idle", 16'(state), 16'd0);
    alarm_en = 1'b1;
    repeat (3) cyc();
    chk_outs("arm_in_match", 2'd1, 1'b0, 1'b0, 1'b0, 4'd0);
    retrigger();
    chk_outs("edge_ring", 2'd2, 1'b1, 1'b1, 1'b0, LEFT_ON_RING);

`ifdef ALARM_SNOOZE_EN
    // 3: snooze coinciding with a tick: the tick is dropped, full 3-tick snooze follows.
    press(1'b1, 1'b0, 1'b1);
    chk_outs("snooze1", 2'd3, 1'b0, 1'b0, 1'b1, 4'd1);
    tick(); tick();
    chk("snooze1_hold", 16'(snoozing), 16'd1);
    tick();
    chk_outs("resume1", 2'd2, 1'b1, 1'b1, 1'b0, 4'd1);
    press(1'b1, 1'b0, 1'b0);
    chk_outs("snooze2", 2'd3, 1'b0, 1'b0, 1'b1, 4'd0);
    repeat (3) tick();
    chk_outs("resume2", 2'd2, 1'b1, 1'b1, 1'b0, 4'd0);
    press(1'b1, 1'b0, 1'b0);
    chk_outs("snooze3_ignored", 2'd2, 1'b1, 1'b1, 1'b0, 4'd0);

    // 4: stop and snooze together while ringing with snoozes left -> ARMED.
    press(1'b0, 1'b1, 1'b0);
    retrigger();
    chk("ring_reload_left", 16'(snooze_left), 16'd2);
    press(1'b1, 1'b1, 1'b0);
    chk_outs("stop_beats_snooze", 2'd1, 1'b0, 1'b0, 1'b0, 4'd0);

    // 5: disable during SNOOZE drops to IDLE with everything cleared.
    retrigger();
    press(1'b1, 1'b0, 1'b0);
    chk("snooze_before_disable", 16'(state), 16'd3);
    alarm_en = 1'b0;
    cyc();
    chk_outs("disable_in_snooze", 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    alarm_en = 1'b1;
    cyc();
`else
    // 6: snooze is ignored; ringing runs the full 5 ticks.
    press(1'b1, 1'b0, 1'b0);
    chk_outs("snooze_ignored", 2'd2, 1'b1, 1'b1, 1'b0, 4'd0);
    repeat (4) tick();
    chk_outs("still_ringing", 2'd2, 1'b1, 1'b1, 1'b0, 4'd0);
    press(1'b1, 1'b0, 1'b1);
    chk_outs("timeout_nosnz", 2'd1, 1'b0, 1'b0, 1'b0, 4'd0);

    // Stop coinciding with a tick ends the ring.
    retrigger();
    press(1'b0, 1'b1, 1'b1);
    chk_outs("stop_with_tick", 2'd1, 1'b0, 1'b0, 1'b0, 4'd0);

    // Disable while ringing drops to IDLE.
    retrigger();
    alarm_en = 1'b0;
    cyc();
    chk_outs("disable_in_ring", 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    alarm_en = 1'b1;
    cyc();
`endif

    // Asynchronous reset mid-ring clears outputs without a clock edge.
    retrigger();
    chk("ring_before_reset", 16'(ringing), 16'd1);
    rst_n = 1'b0;
    #2;
    chk_outs("async_reset", 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
